// File: rtl/des_sbox_pkg.sv
// Shared S-box constants, types and the reference lookup for the DES substitution layer.
// Each table row packs 16 nibbles, column 0 in the most significant nibble.
package des_sbox_pkg;

   typedef logic [2:0] sbox_idx_t;
   typedef logic [5:0] sbox_chunk_t;
   typedef logic [3:0] sbox_nib_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int SBOX_COUNT = 8;

   localparam logic [63:0] SBOX_TABLE [8][4] = '{
      '{64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D},
      '{64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9},
      '{64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C},
      '{64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E},
      '{64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453},
      '{64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D},
      '{64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C},
      '{64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B}
   };

   function automatic sbox_nib_t sbox_lookup(input sbox_idx_t idx, input sbox_chunk_t chunk);
      logic [1:0]  row;
      logic [3:0]  col;
      logic [63:0] row_bits;
      row      = {chunk[5], chunk[0]};
      col      = chunk[4:1];
      row_bits = SBOX_TABLE[idx][row];
      return sbox_nib_t'(row_bits >> (60 - 4 * int'(col)));
   endfunction

endpackage

// File: rtl/des_sbox_lookup.sv
// One combinational S-box lane: selects box idx and substitutes a 6-bit chunk.
// Zero latency, no handshake; the enclosing unit owns all flow control.
module des_sbox_lookup
   import des_sbox_pkg::*;
(
   input  sbox_idx_t   idx,
   input  sbox_chunk_t chunk,
   output sbox_nib_t   value
);

   assign value = sbox_lookup(idx, chunk);

endmodule

// File: rtl/des_sbox_unit.sv
// DES S1..S8 substitution of a 48-bit half-block, LANES boxes per cycle; result after 8/LANES cycles.
// valid/ready both sides; DONE holds the result until out_ready, and accepts the next block on that same cycle.
module des_sbox_unit
   import des_sbox_pkg::*;
#(
   parameter int LANES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [47:0] in_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic        busy
);

   if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8) begin : g_bad_lanes
      $error("des_sbox_unit: LANES must be 1, 2, 4 or 8");
   end

   localparam int         STEPS     = SBOX_COUNT / LANES;
   localparam logic [2:0] LAST_STEP = 3'(STEPS - 1);

   state_t      state_q, state_d;
   logic [2:0]  step_q, step_d;
   logic [47:0] in_reg, in_reg_d;
   logic [31:0] res_q, res_d, res_lanes;
   logic        take;

   sbox_idx_t   lane_idx   [LANES];
   sbox_chunk_t lane_chunk [LANES];
   sbox_nib_t   lane_val   [LANES];
   logic [4:0]  nib_shift  [LANES];

   for (genvar j = 0; j < LANES; j++) begin : g_lane
      assign lane_idx[j]   = sbox_idx_t'(int'(step_q) * LANES + j);
      assign lane_chunk[j] = sbox_chunk_t'(in_reg >> (42 - 6 * int'(lane_idx[j])));
      assign nib_shift[j]  = 5'(28 - 4 * int'(lane_idx[j]));

      des_sbox_lookup u_lookup (
         .idx   (lane_idx[j]),
         .chunk (lane_chunk[j]),
         .value (lane_val[j])
      );
   end

   // Lanes always cover distinct boxes, so each nibble is replaced independently.
   always_comb begin
      res_lanes = res_q;
      for (int j = 0; j < LANES; j++) begin
         res_lanes = (res_lanes & ~(32'hF << nib_shift[j]))
                   | ({28'h0, lane_val[j]} << nib_shift[j]);
      end
   end

   always_comb begin
      state_d   = state_q;
      step_d    = step_q;
      in_reg_d  = in_reg;
      res_d     = res_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      take      = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            in_ready = 1'b1;
            take     = in_valid;
         end
         ST_BUSY: begin
            busy   = 1'b1;
            res_d  = res_lanes;
            step_d = step_q + 3'd1;
            if (step_q == LAST_STEP) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            out_valid = 1'b1;
            in_ready  = out_ready;
            if (out_ready) begin
               take = in_valid;
               if (!in_valid) begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (take) begin
         in_reg_d = in_data;
         res_d    = '0;
         step_d   = '0;
         state_d  = ST_BUSY;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         step_q  <= '0;
         in_reg  <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         in_reg  <= in_reg_d;
         res_q   <= res_d;
      end
   end

   assign out_data = res_q;

endmodule

// File: tb/tb_des_sbox_unit.sv
// Bench for des_sbox_unit at LANES 8, 2 and 1 against an independent FIPS table model.
module tb_des_sbox_unit;

   logic        clk;
   logic        rst_n     [3];
   logic        in_valid  [3];
   logic        in_ready  [3];
   logic [47:0] in_data   [3];
   logic        out_valid [3];
   logic        out_ready [3];
   logic [31:0] out_data  [3];
   logic        busy      [3];

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   bit l8_done = 0;

   // Instance 0: LANES=8, instance 1: LANES=2, instance 2: LANES=1.
   int steps [3] = '{1, 4, 8};

   bit          pend    [3];
   int          acc_cyc [3];
   logic [31:0] exp_dat [3];

   int tbl [8][4][16] = '{
      '{'{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7}, '{0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8},
        '{4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0}, '{15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13}},
      '{'{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10}, '{3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5},
        '{0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15}, '{13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9}},
      '{'{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8}, '{13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1},
        '{13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7}, '{1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12}},
      '{'{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15}, '{13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9},
        '{10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4}, '{3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14}},
      '{'{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9}, '{14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6},
        '{4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14}, '{11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3}},
      '{'{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11}, '{10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8},
        '{9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6}, '{4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13}},
      '{'{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1}, '{13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6},
        '{1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2}, '{6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12}},
      '{'{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7}, '{1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2},
        '{7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8}, '{2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}}
   };

   des_sbox_unit #(.LANES(8)) u_l8 (
      .clk(clk), .rst_n(rst_n[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .in_data(in_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
      .out_data(out_data[0]), .busy(busy[0]));
   des_sbox_unit #(.LANES(2)) u_l2 (
      .clk(clk), .rst_n(rst_n[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .in_data(in_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
      .out_data(out_data[1]), .busy(busy[1]));
   des_sbox_unit #(.LANES(1)) u_l1 (
      .clk(clk), .rst_n(rst_n[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
      .in_data(in_data[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
      .out_data(out_data[2]), .busy(busy[2]));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int ref_box(input int b, input int c);
      int row, col;
      row = ((c >> 4) & 2) | (c & 1);
      col = (c >> 1) & 15;
      return tbl[b][row][col];
   endfunction

   function automatic logic [31:0] ref_sub(input logic [47:0] d);
      logic [31:0] r;
      r = '0;
      for (int b = 0; b < 8; b++) begin
         r = (r << 4) | 32'(ref_box(b, int'((d >> (42 - 6 * b)) & 48'h3F)));
      end
      return r;
   endfunction

   function automatic logic [47:0] rand48();
      return 48'({$urandom(), $urandom()});
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", nm, act, req);
      end
   endtask

   // Timing model: a block accepted at an edge must show its result from STEPS edges later
   // until the output handshake; before that the unit reports busy and refuses input.
   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         automatic bit ev;
         automatic bit eir;
         if (!rst_n[i]) begin
            chk($sformatf("i%0d_rst_in_ready", i), 32'(in_ready[i]), 32'd1);
            chk($sformatf("i%0d_rst_out_valid", i), 32'(out_valid[i]), 32'd0);
            chk($sformatf("i%0d_rst_busy", i), 32'(busy[i]), 32'd0);
            chk($sformatf("i%0d_rst_out_data", i), out_data[i], 32'h0);
            pend[i] <= 1'b0;
         end else begin
            ev  = pend[i] && (cyc >= acc_cyc[i] + steps[i]);
            eir = !pend[i] || (ev && out_ready[i]);
            chk($sformatf("i%0d_out_valid@%0d", i, cyc), 32'(out_valid[i]), 32'(ev));
            chk($sformatf("i%0d_in_ready@%0d", i, cyc), 32'(in_ready[i]), 32'(eir));
            chk($sformatf("i%0d_busy@%0d", i, cyc), 32'(busy[i]), 32'(pend[i] && !ev));
            if (ev) chk($sformatf("i%0d_out_data@%0d", i, cyc), out_data[i], exp_dat[i]);
            if (ev && out_ready[i]) pend[i] <= 1'b0;
            if (in_valid[i] && eir) begin
               pend[i]    <= 1'b1;
               acc_cyc[i] <= cyc + 1;
               exp_dat[i] <= ref_sub(in_data[i]);
            end
         end
      end
   end

   task automatic send(input int i, input logic [47:0] d);
      bit ok;
      ok = 0;
      in_data[i]  = d;
      in_valid[i] = 1'b1;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (in_ready[i]) begin
            ok = 1;
            break;
         end
      end
      chk($sformatf("i%0d_accept_in_time", i), 32'(ok), 32'd1);
      @(posedge clk);
      #1;
      in_valid[i] = 1'b0;
   endtask

   task automatic wait_out(input int i, input int lat_req, input logic [31:0] d_req, input string nm);
      int  lat;
      bit  ok;
      lat = 0;
      ok  = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (out_valid[i]) begin
            ok = 1;
            break;
         end
         lat++;
      end
      chk({nm, "_seen"}, 32'(ok), 32'd1);
      chk({nm, "_latency"}, 32'(lat), 32'(lat_req));
      chk({nm, "_data"}, out_data[i], d_req);
   endtask

   task automatic wait_idle(input int i);
      bit ok;
      ok = 0;
      out_ready[i] = 1'b1;
      in_valid[i]  = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (!busy[i] && !out_valid[i]) begin
            ok = 1;
            break;
         end
      end
      chk($sformatf("i%0d_drain", i), 32'(ok), 32'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic run_l8();
      send(0, 48'h0);
      wait_out(0, 1, 32'hEFA72C4D, "l8_zero");
      send(0, 48'h0010_0000_0000);
      wait_out(0, 1, 32'hE3A72C4D, "l8_s2_row1");
      fork
         begin
            while (!l8_done) begin
               @(posedge clk);
               #1;
               if (!l8_done) out_ready[0] = ($urandom_range(0, 3) != 0);
            end
            out_ready[0] = 1'b1;
         end
      join_none
      // Same chunk in all eight positions: 64 blocks cover every entry of every box.
      for (int c = 0; c < 64; c++) begin
         logic [5:0] c6;
         c6 = 6'(c);
         send(0, {8{c6}});
      end
      for (int n = 0; n < 20; n++) send(0, rand48());
      l8_done = 1;
      wait_idle(0);
   endtask

   task automatic run_l2();
      int prev;
      int t;
      bit ok;
      logic [47:0] d;
      logic [31:0] held;
      out_ready[1] = 1'b1;
      in_valid[1]  = 1'b1;
      prev = 0;
      // The next accept rides on the DONE cycle, so accepts are STEPS busy cycles plus that one apart.
      for (int n = 0; n < 16; n++) begin
         in_data[1] = rand48();
         ok = 0;
         for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (in_ready[1]) begin
               ok = 1;
               break;
            end
         end
         chk("l2_stream_accept", 32'(ok), 32'd1);
         t = cyc;
         if (n > 0) chk("l2_stream_spacing", 32'(t - prev), 32'd5);
         prev = t;
         @(posedge clk);
         #1;
      end
      in_valid[1] = 1'b0;
      wait_idle(1);

      out_ready[1] = 1'b0;
      d = rand48();
      held = ref_sub(d);
      send(1, d);
      wait_out(1, 4, held, "l2_bp_first");
      @(posedge clk);
      #1;
      in_valid[1] = 1'b1;
      in_data[1]  = rand48();
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk("l2_bp_hold_data", out_data[1], held);
         chk("l2_bp_hold_in_ready", 32'(in_ready[1]), 32'd0);
      end
      @(posedge clk);
      #1;
      in_valid[1]  = 1'b0;
      out_ready[1] = 1'b1;
      @(posedge clk);
      #1;
      out_ready[1] = 1'b0;
      @(negedge clk);
      chk("l2_bp_single_release", 32'(out_valid[1]), 32'd0);
      chk("l2_bp_back_to_idle", 32'(in_ready[1]), 32'd1);
      out_ready[1] = 1'b1;

      for (int n = 0; n < 4; n++) begin
         send(1, rand48());
         for (int k = 0; k < 3; k++) begin
            in_valid[1] = 1'($urandom_range(0, 1));
            in_data[1]  = rand48();
            @(posedge clk);
            #1;
         end
         in_valid[1] = 1'b0;
         wait_idle(1);
      end
   endtask

   task automatic run_l1();
      send(2, 48'h0);
      wait_out(2, 8, 32'hEFA72C4D, "l1_zero");
      send(2, rand48());
      repeat (3) @(posedge clk);
      #1;
      rst_n[2] = 1'b0;
      @(negedge clk);
      chk("l1_rst_mid_busy_out_valid", 32'(out_valid[2]), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n[2] = 1'b1;
      @(negedge clk);
      chk("l1_after_rst_in_ready", 32'(in_ready[2]), 32'd1);
      chk("l1_after_rst_out_valid", 32'(out_valid[2]), 32'd0);
      @(posedge clk);
      #1;
      send(2, 48'h0);
      wait_out(2, 8, 32'hEFA72C4D, "l1_after_rst");
      for (int n = 0; n < 6; n++) send(2, rand48());
      wait_idle(2);
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         rst_n[i]     = 1'b1;
         in_valid[i]  = 1'b0;
         in_data[i]   = '0;
         out_ready[i] = 1'b1;
         pend[i]      = 1'b0;
         acc_cyc[i]   = 0;
         exp_dat[i]   = '0;
      end
      #1;
      for (int i = 0; i < 3; i++) rst_n[i] = 1'b0;

      chk("model_zero", ref_sub(48'h0), 32'hEFA72C4D);
      chk("model_s2_row1", ref_sub(48'h0010_0000_0000), 32'hE3A72C4D);
      chk("model_s1_c63", 32'(ref_box(0, 63)), 32'd13);
      for (int b = 0; b < 8; b++) begin
         for (int c = 0; c < 64; c++) begin
            chk($sformatf("pkg_s%0d_c%0d", b + 1, c),
                32'(des_sbox_pkg::sbox_lookup(3'(b), 6'(c))), 32'(ref_box(b, c)));
         end
      end

      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;
      @(posedge clk);
      #1;
      fork
         run_l8();
         run_l2();
         run_l1();
      join
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
      $fatal(1, "watchdog expired");
   end

endmodule
